// File: rtl/clk_div_bank.sv
// Bank of NCH programmable clock-enable dividers. Each channel emits a one-cycle
// tick and a toggle/pulse wave; divisor and mode changes are applied only at period boundaries.
module clk_div_bank #(
  parameter int NCH = 3,
  parameter int CW  = 16,
  parameter int CHW = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic [NCH-1:0] ch_en,
  input  logic           sync,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic           cfg_mode,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] wave,
  output logic [NCH-1:0] active
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CW-1:0] count;
    logic [CW-1:0] div_a;
    logic [CW-1:0] div_s;
    logic          mode_a;
    logic          mode_s;
    logic          pending;
    logic          tick_p1;
    logic          wave_p1;
    logic          running;
    logic          terminal;
    logic          wr;
    logic          apply;

    assign running  = enable & ch_en[g] & (div_a != '0);
    assign terminal = running & (count == div_a);
    // Indices at or above NCH match no channel, so such writes fall away here.
    assign wr       = cfg_we & (cfg_ch == CHW'(g));
    // A write landing in the same cycle defers the apply so the new shadow is not lost.
    assign apply    = pending & ~wr & (sync | terminal | ~running);

    // Stage p1: registered counter, strobe and waveform
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        count   <= '0;
        div_a   <= '0;
        div_s   <= '0;
        mode_a  <= 1'b0;
        mode_s  <= 1'b0;
        pending <= 1'b0;
        tick_p1 <= 1'b0;
        wave_p1 <= 1'b0;
      end else begin
        if (sync) begin
          count   <= '0;
          tick_p1 <= 1'b0;
          wave_p1 <= 1'b0;
        end else if (terminal) begin
          count   <= '0;
          tick_p1 <= 1'b1;
          wave_p1 <= mode_a ? 1'b1 : ~wave_p1;
        end else if (running) begin
          count   <= count + CW'(1);
          tick_p1 <= 1'b0;
          if (mode_a) wave_p1 <= 1'b0;
        end else begin
          tick_p1 <= 1'b0;
          if (mode_a || (div_a == '0)) wave_p1 <= 1'b0;
          if (div_a == '0) count <= '0;
        end

        if (apply) begin
          div_a  <= div_s;
          mode_a <= mode_s;
          if (!running) count <= '0;
        end

        if (wr) begin
          div_s   <= cfg_div;
          mode_s  <= cfg_mode;
          pending <= 1'b1;
        end else if (apply) begin
          pending <= 1'b0;
        end
      end
    end

    assign tick[g]   = tick_p1;
    assign wave[g]   = wave_p1;
    assign active[g] = running;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: stimulus queues expected ticks (cycle, wave),
// a negedge monitor pops and compares every tick and flags missing ones.
module tb_clk_div_bank;
  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int CHW = 2;

  logic           clk;
  logic           reset_n;
  logic           enable;
  logic [NCH-1:0] ch_en;
  logic           sync;
  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_mode;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] wave;
  logic [NCH-1:0] active;

  clk_div_bank #(.NCH(NCH), .CW(CW), .CHW(CHW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ch_en(ch_en), .sync(sync),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .tick(tick), .wave(wave), .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int cyc;
    bit wv;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic void push(int ch, int c, bit wv);
    exp_t e;
    e.ch = ch;
    e.cyc = c;
    e.wv = wv;
    sb.push_back(e);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: each tick must match the oldest expectation for its channel.
  always @(negedge clk) begin
    int idx;
    if (reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        idx = -1;
        for (int k = 0; k < sb.size(); k++)
          if (idx < 0 && sb[k].ch == c) idx = k;
        if (tick[c]) begin
          checks++;
          if (idx < 0) begin
            failures++;
            $display("FAIL tick_unexpected ch=%0d actual_cycle=%0d expected=none", c, cyc);
          end else begin
            if (sb[idx].cyc != cyc || wave[c] != sb[idx].wv) begin
              failures++;
              $display("FAIL tick ch=%0d actual cycle=%0d wave=%0b expected cycle=%0d wave=%0b",
                       c, cyc, wave[c], sb[idx].cyc, sb[idx].wv);
            end
            sb.delete(idx);
          end
        end else if (idx >= 0 && sb[idx].cyc <= cyc) begin
          checks++;
          failures++;
          $display("FAIL tick_missing ch=%0d actual=none expected cycle=%0d", c, sb[idx].cyc);
          sb.delete(idx);
        end
      end
    end
  end

  task automatic run_until(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic cfg_write(int ch, int d, bit m);
    cfg_we   = 1'b1;
    cfg_ch   = CHW'(ch);
    cfg_div  = CW'(d);
    cfg_mode = m;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    chk("leftover_expectations", sb.size(), 0);
    sb.delete();
    reset_n = 1'b0;
    enable  = 1'b0;
    ch_en   = '0;
    sync    = 1'b0;
    cfg_we  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  int w;
  int s;

  initial begin
    reset_n = 1'b1; enable = 1'b0; ch_en = '0; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_tick", tick, 0);
    chk("reset_wave", wave, 0);
    chk("reset_active", active, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // ch0 D=3 toggle: tick every 4, wave period 8
    enable = 1'b1; ch_en = '1;
    cfg_write(0, 3, 1'b0); w = cyc;
    push(0, w + 5, 1'b1); push(0, w + 9, 1'b0); push(0, w + 13, 1'b1); push(0, w + 17, 1'b0);
    run_until(w + 1);  chk("A_active", active, 3'b001);
    run_until(w + 7);  chk("A_wave_high", wave, 3'b001);
    run_until(w + 19); chk("A_wave_low", wave, 3'b000);
    do_reset();

    // illegal channel index, then ch1 D=1 pulse
    enable = 1'b1; ch_en = '1;
    cfg_write(3, 5, 1'b0); w = cyc;
    run_until(w + 2);  chk("B_badch_active", active, 0);
    cfg_write(1, 1, 1'b1); w = cyc;
    push(1, w + 3, 1'b1); push(1, w + 5, 1'b1); push(1, w + 7, 1'b1); push(1, w + 9, 1'b1);
    run_until(w + 4);  chk("B_pulse_low", wave, 0);
    chk("B_active", active, 3'b010);
    run_until(w + 10);
    do_reset();

    // retarget while running, two writes before the boundary: last wins
    enable = 1'b1; ch_en = '1;
    cfg_write(0, 3, 1'b0); w = cyc;
    push(0, w + 5, 1'b1); push(0, w + 9, 1'b0); push(0, w + 17, 1'b1); push(0, w + 25, 1'b0);
    run_until(w + 5);
    cfg_write(0, 5, 1'b0);
    cfg_write(0, 7, 1'b0);
    run_until(w + 27);
    do_reset();

    // sync aligns ch0 D=2 and ch1 D=5; ch2 write on sync cycle applies one edge later
    enable = 1'b1; ch_en = '1;
    cfg_write(0, 2, 1'b0); w = cyc;
    cfg_write(1, 5, 1'b0);
    s = w + 6;
    push(0, w + 4, 1'b1);
    push(0, s + 3, 1'b1); push(0, s + 6, 1'b0); push(0, s + 9, 1'b1); push(0, s + 12, 1'b0);
    push(1, s + 6, 1'b1); push(1, s + 12, 1'b0);
    push(2, s + 6, 1'b1); push(2, s + 11, 1'b1);
    run_until(s - 1);
    sync = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd4; cfg_mode = 1'b1;
    @(negedge clk);
    sync = 1'b0; cfg_we = 1'b0;
    chk("D_sync_wave", wave, 0);
    chk("D_sync_pending", active, 3'b011);
    run_until(s + 1);  chk("D_applied", active, 3'b111);
    run_until(s + 13);
    do_reset();

    // enable low 5 cycles: period stretch, toggle wave held, pulse wave cleared
    enable = 1'b1; ch_en = '1;
    cfg_write(0, 3, 1'b0); w = cyc;
    cfg_write(1, 3, 1'b1);
    push(0, w + 5, 1'b1);  push(1, w + 6, 1'b1);
    push(0, w + 14, 1'b0); push(1, w + 15, 1'b1);
    push(0, w + 18, 1'b1); push(1, w + 19, 1'b1);
    run_until(w + 6);  enable = 1'b0;
    run_until(w + 9);
    chk("E_wave_frozen", wave, 3'b001);
    chk("E_active_off", active, 0);
    run_until(w + 11); enable = 1'b1;
    run_until(w + 20);
    do_reset();

    // asynchronous reset between edges
    enable = 1'b1; ch_en = '1;
    cfg_write(0, 3, 1'b0); w = cyc;
    push(0, w + 5, 1'b1);
    run_until(w + 5);
    chk("F_pre_state", {29'd0, tick[0], wave[0], active[0]}, 32'b111);
    #2 reset_n = 1'b0;
    #1;
    chk("F_async_tick", tick, 0);
    chk("F_async_wave", wave, 0);
    chk("F_async_active", active, 0);
    chk("F_leftover", sb.size(), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    w = cyc;
    run_until(w + 12);
    chk("F_idle_active", active, 0);
    chk("F_idle_wave", wave, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
